// File: rtl/stream_rr_arbiter.sv
// Packet-level round-robin arbiter feeding one registered valid/ready stage.
// Each output beat is tagged with the index of the input it came from.
module stream_rr_arbiter #(
    parameter int NUM_IN = 4,
    parameter int WIDTH  = 8,
    parameter int SRC_W  = $clog2(NUM_IN)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NUM_IN*WIDTH-1:0] i_data,
    input  logic [NUM_IN-1:0]       i_vld,
    input  logic [NUM_IN-1:0]       i_last,
    output logic [NUM_IN-1:0]       o_rdy,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_last,
    output logic [SRC_W-1:0]        o_src,
    output logic                    o_vld,
    input  logic                    i_rdy
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [SRC_W-1:0] grant_q, grant_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;

    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic             vld_q, vld_d;

    logic [SRC_W:0]   pick;
    logic [SRC_W-1:0] sel;
    logic             sel_en;
    logic             can_accept;
    logic             grant_ok;
    logic             accept;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;

    // Search starts just after ptr and wraps at NUM_IN, not at 2**SRC_W.
    // Iterating far-to-near lets the nearest requester overwrite the result.
    function automatic logic [SRC_W:0] rr_pick(
        input logic [NUM_IN-1:0] req,
        input logic [SRC_W-1:0]  ptr
    );
        logic [SRC_W:0] res;
        int             idx;
        res = '0;
        for (int off = NUM_IN; off >= 1; off--) begin
            idx = (int'(ptr) + off) % NUM_IN;
            if (req[idx]) begin
                res = {1'b1, SRC_W'(idx)};
            end
        end
        return res;
    endfunction

    assign can_accept = !vld_q || i_rdy;

    always_comb begin
        pick   = rr_pick(i_vld, ptr_q);
        sel    = pick[SRC_W-1:0];
        sel_en = pick[SRC_W];
        if (state_q == LOCKED) begin
            sel    = grant_q;
            sel_en = 1'b1;
        end
    end

    assign grant_ok = sel_en && can_accept && !i_reset;
    assign accept   = grant_ok && i_vld[sel];
    assign sel_last = i_last[sel];
    assign sel_data = i_data[int'(sel)*WIDTH +: WIDTH];

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= SRC_W'(NUM_IN - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (accept) begin
            if (sel_last) begin
                state_d = IDLE;
                ptr_d   = sel;
            end else begin
                state_d = LOCKED;
                grant_d = sel;
            end
        end
    end

    // Output logic: ready goes only to the selected input
    always_comb begin
        o_rdy = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            o_rdy[k] = grant_ok && (sel == SRC_W'(k));
        end
    end

    always_comb begin
        data_d = data_q;
        last_d = last_q;
        src_d  = src_q;
        vld_d  = vld_q;
        if (accept) begin
            data_d = sel_data;
            last_d = sel_last;
            src_d  = sel;
            vld_d  = 1'b1;
        end else if (i_rdy) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_q <= '0;
            last_q <= 1'b0;
            src_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            last_q <= last_d;
            src_q  <= src_d;
            vld_q  <= vld_d;
        end
    end

    assign o_data = data_q;
    assign o_last = last_q;
    assign o_src  = src_q;
    assign o_vld  = vld_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed and randomized checks for stream_rr_arbiter.
// Inputs are fed from per-source beat queues that respect the valid contract.
module tb_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          i_reset;
    logic [N*W-1:0] i_data;
    logic [N-1:0]  i_vld;
    logic [N-1:0]  i_last;
    logic [N-1:0]  o_rdy;
    logic [W-1:0]  o_data;
    logic          o_last;
    logic [SW-1:0] o_src;
    logic          o_vld;
    logic          i_rdy;

    always #5 clk = ~clk;

    stream_rr_arbiter #(
        .NUM_IN(N),
        .WIDTH (W),
        .SRC_W (SW)
    ) dut (
        .i_clk  (clk),
        .i_reset(i_reset),
        .i_data (i_data),
        .i_vld  (i_vld),
        .i_last (i_last),
        .o_rdy  (o_rdy),
        .o_data (o_data),
        .o_last (o_last),
        .o_src  (o_src),
        .o_vld  (o_vld),
        .i_rdy  (i_rdy)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Beat encoding: {last, data}
    logic [8:0]    srcq [N][$];
    logic [8:0]    acc_beat [N];
    logic [N-1:0]  rdy_s;
    logic [N-1:0]  acc_s;
    logic          xfer_s;
    logic [W-1:0]  xd_s;
    logic [SW-1:0] xsrc_s;
    logic          xlast_s;

    task automatic drive();
        logic [8:0] b;
        for (int k = 0; k < N; k++) begin
            if (srcq[k].size() > 0) begin
                b = srcq[k][0];
                i_vld[k] = 1'b1;
                i_last[k] = b[8];
                i_data[k*W +: W] = b[7:0];
            end else begin
                i_vld[k] = 1'b0;
                i_last[k] = 1'b0;
                i_data[k*W +: W] = '0;
            end
        end
    endtask

    // Called at posedge+1; samples handshakes at the falling edge,
    // crosses one rising edge and returns at posedge+1.
    task automatic tick();
        drive();
        #4;
        rdy_s   = o_rdy;
        acc_s   = o_rdy & i_vld;
        xfer_s  = o_vld && i_rdy;
        xd_s    = o_data;
        xsrc_s  = o_src;
        xlast_s = o_last;
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            if (acc_s[k]) begin
                acc_beat[k] = srcq[k].pop_front();
            end
        end
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_rdy = 1'b1;
        i_reset = 1'b1;
        for (int k = 0; k < N; k++) srcq[k].push_back({1'b1, 8'hAA});
        tick();
        total_cnt++;
        if (rdy_s !== 4'b0000) $display("FAIL reset_rdy got=%b exp=0000", rdy_s);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (rdy_s !== 4'b0000) $display("FAIL reset_rdy2 got=%b exp=0000", rdy_s);
        else pass_cnt++;
        total_cnt++;
        if (o_vld !== 1'b0) $display("FAIL reset_vld got=%b exp=0", o_vld);
        else pass_cnt++;
        total_cnt++;
        if (o_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", o_data);
        else pass_cnt++;
        total_cnt++;
        if (o_last !== 1'b0 || o_src !== 2'd0)
            $display("FAIL reset_last_src got=%b/%0d exp=0/0", o_last, o_src);
        else pass_cnt++;
        i_reset = 1'b0;
        for (int k = 0; k < N; k++) srcq[k].delete();
    endtask

    task automatic test_rr_single();
        logic [N-1:0] er;
        logic [W-1:0] ed;
        for (int k = 0; k < N; k++) srcq[k].push_back({1'b1, 8'(8'h10 + k)});
        for (int k = 0; k < N; k++) begin
            tick();
            er = 4'b0001 << k;
            ed = 8'(8'h10 + k);
            total_cnt++;
            if (rdy_s !== er) $display("FAIL rr_rdy%0d got=%b exp=%b", k, rdy_s, er);
            else pass_cnt++;
            total_cnt++;
            if (o_vld !== 1'b1 || o_src !== SW'(k) || o_data !== ed || o_last !== 1'b1)
                $display("FAIL rr_beat%0d got=v%b s%0d d%h l%b exp=v1 s%0d d%h l1",
                         k, o_vld, o_src, o_data, o_last, k, ed);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (o_vld !== 1'b0) $display("FAIL rr_drain got=%b exp=0", o_vld);
        else pass_cnt++;
    endtask

    task automatic test_multi_beat();
        logic [N-1:0]  er;
        logic [SW-1:0] es;
        logic [W-1:0]  ed;
        srcq[1].push_back({1'b0, 8'hA0});
        srcq[1].push_back({1'b0, 8'hA1});
        srcq[1].push_back({1'b1, 8'hA2});
        srcq[2].push_back({1'b1, 8'hB0});
        for (int i = 0; i < 4; i++) begin
            tick();
            er = (i < 3) ? 4'b0010 : 4'b0100;
            es = (i < 3) ? 2'd1 : 2'd2;
            ed = (i < 3) ? 8'(8'hA0 + i) : 8'hB0;
            total_cnt++;
            if (rdy_s !== er) $display("FAIL mb_rdy%0d got=%b exp=%b", i, rdy_s, er);
            else pass_cnt++;
            total_cnt++;
            if (o_vld !== 1'b1 || o_src !== es || o_data !== ed || o_last !== (i >= 2))
                $display("FAIL mb_beat%0d got=v%b s%0d d%h l%b exp=v1 s%0d d%h l%b",
                         i, o_vld, o_src, o_data, o_last, es, ed, (i >= 2));
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (o_vld !== 1'b0) $display("FAIL mb_drain got=%b exp=0", o_vld);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        srcq[0].push_back({1'b1, 8'h55});
        srcq[0].push_back({1'b1, 8'h56});
        tick();
        total_cnt++;
        if (o_vld !== 1'b1 || o_data !== 8'h55)
            $display("FAIL bp_first got=v%b d%h exp=v1 d55", o_vld, o_data);
        else pass_cnt++;
        i_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++;
            if (o_vld !== 1'b1 || o_data !== 8'h55 || o_last !== 1'b1 || o_src !== 2'd0)
                $display("FAIL bp_hold%0d got=v%b d%h l%b s%0d exp=v1 d55 l1 s0",
                         i, o_vld, o_data, o_last, o_src);
            else pass_cnt++;
            total_cnt++;
            if (rdy_s !== 4'b0000) $display("FAIL bp_rdy%0d got=%b exp=0000", i, rdy_s);
            else pass_cnt++;
        end
        i_rdy = 1'b1;
        tick();
        total_cnt++;
        if (xfer_s !== 1'b1 || xd_s !== 8'h55)
            $display("FAIL bp_xfer got=x%b d%h exp=x1 d55", xfer_s, xd_s);
        else pass_cnt++;
        total_cnt++;
        if (o_vld !== 1'b1 || o_data !== 8'h56)
            $display("FAIL bp_next got=v%b d%h exp=v1 d56", o_vld, o_data);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (o_vld !== 1'b0) $display("FAIL bp_drain got=%b exp=0", o_vld);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        srcq[2].push_back({1'b0, 8'hE0});
        srcq[2].push_back({1'b0, 8'hE1});
        srcq[2].push_back({1'b0, 8'hE2});
        srcq[2].push_back({1'b1, 8'hE3});
        tick();
        total_cnt++;
        if (o_src !== 2'd2 || o_data !== 8'hE0)
            $display("FAIL rm_lock got=s%0d d%h exp=s2 dE0", o_src, o_data);
        else pass_cnt++;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        total_cnt++;
        if (rdy_s !== 4'b0000) $display("FAIL rm_rdy got=%b exp=0000", rdy_s);
        else pass_cnt++;
        total_cnt++;
        if (o_vld !== 1'b0 || o_data !== 8'h00)
            $display("FAIL rm_out got=v%b d%h exp=v0 d00", o_vld, o_data);
        else pass_cnt++;
        srcq[2].delete();
        srcq[0].push_back({1'b1, 8'hF0});
        srcq[2].push_back({1'b1, 8'hF2});
        tick();
        total_cnt++;
        if (rdy_s !== 4'b0001) $display("FAIL rm_grant got=%b exp=0001", rdy_s);
        else pass_cnt++;
        total_cnt++;
        if (o_src !== 2'd0 || o_data !== 8'hF0)
            $display("FAIL rm_b0 got=s%0d d%h exp=s0 dF0", o_src, o_data);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (o_src !== 2'd2 || o_data !== 8'hF2)
            $display("FAIL rm_b1 got=s%0d d%h exp=s2 dF2", o_src, o_data);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_mid_gap();
        do_reset();
        srcq[0].push_back({1'b0, 8'hC0});
        srcq[3].push_back({1'b1, 8'hD0});
        tick();
        total_cnt++;
        if (rdy_s !== 4'b0001 || o_data !== 8'hC0 || o_last !== 1'b0)
            $display("FAIL gap_first got=r%b d%h l%b exp=r0001 dC0 l0", rdy_s, o_data, o_last);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (rdy_s !== 4'b0001) $display("FAIL gap_rdy%0d got=%b exp=0001", i, rdy_s);
            else pass_cnt++;
            total_cnt++;
            if (o_vld !== 1'b0) $display("FAIL gap_vld%0d got=%b exp=0", i, o_vld);
            else pass_cnt++;
        end
        srcq[0].push_back({1'b1, 8'hC1});
        tick();
        total_cnt++;
        if (o_vld !== 1'b1 || o_src !== 2'd0 || o_data !== 8'hC1 || o_last !== 1'b1)
            $display("FAIL gap_last got=v%b s%0d d%h l%b exp=v1 s0 dC1 l1",
                     o_vld, o_src, o_data, o_last);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (rdy_s !== 4'b1000 || o_src !== 2'd3 || o_data !== 8'hD0)
            $display("FAIL gap_next got=r%b s%0d d%h exp=r1000 s3 dD0", rdy_s, o_src, o_data);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_soak();
        logic [8:0]    expq [N][$];
        int            grants [N];
        logic          mid [N];
        logic          in_pkt;
        logic [SW-1:0] cur;
        logic [8:0]    e;
        int            len;
        int            mn;
        int            mx;
        logic          sat;
        do_reset();
        in_pkt = 1'b0;
        cur = '0;
        for (int k = 0; k < N; k++) begin
            grants[k] = 0;
            mid[k] = 1'b0;
        end
        for (int cyc = 0; cyc < 2100; cyc++) begin
            sat = (cyc < 1000);
            if (cyc < 2000) begin
                for (int k = 0; k < N; k++) begin
                    if (sat ? (srcq[k].size() < 5)
                            : (srcq[k].size() == 0 && $urandom_range(0, 3) == 0)) begin
                        len = $urandom_range(1, 4);
                        for (int b = 0; b < len; b++)
                            srcq[k].push_back({(b == len - 1), 8'($urandom)});
                    end
                end
                i_rdy = ($urandom_range(0, 3) != 0);
            end else begin
                i_rdy = 1'b1;
            end
            tick();
            for (int k = 0; k < N; k++) begin
                if (acc_s[k]) begin
                    expq[k].push_back(acc_beat[k]);
                    if (!mid[k] && sat) grants[k]++;
                    mid[k] = !acc_beat[k][8];
                end
            end
            if (xfer_s) begin
                if (in_pkt) begin
                    total_cnt++;
                    if (xsrc_s !== cur)
                        $display("FAIL soak_interleave cyc=%0d got=s%0d exp=s%0d", cyc, xsrc_s, cur);
                    else pass_cnt++;
                end
                total_cnt++;
                if (expq[xsrc_s].size() == 0) begin
                    $display("FAIL soak_extra cyc=%0d got=s%0d d%h exp=none", cyc, xsrc_s, xd_s);
                end else begin
                    e = expq[xsrc_s].pop_front();
                    if ({xlast_s, xd_s} !== e)
                        $display("FAIL soak_data cyc=%0d s%0d got=%h exp=%h",
                                 cyc, xsrc_s, {xlast_s, xd_s}, e);
                    else pass_cnt++;
                end
                in_pkt = !xlast_s;
                cur = xsrc_s;
            end
            if (cyc == 999) begin
                mn = grants[0];
                mx = grants[0];
                for (int k = 1; k < N; k++) begin
                    if (grants[k] < mn) mn = grants[k];
                    if (grants[k] > mx) mx = grants[k];
                end
                total_cnt++;
                if (mx - mn > 1 || mx == 0)
                    $display("FAIL soak_fair got=min%0d max%0d exp=spread<=1", mn, mx);
                else pass_cnt++;
            end
        end
        for (int k = 0; k < N; k++) begin
            total_cnt++;
            if (expq[k].size() != 0 || srcq[k].size() != 0)
                $display("FAIL soak_left%0d got=%0d/%0d exp=0/0", k, expq[k].size(), srcq[k].size());
            else pass_cnt++;
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_rdy   = 1'b1;
        i_vld   = '0;
        i_last  = '0;
        i_data  = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_rr_single();
        test_multi_beat();
        test_backpressure();
        test_reset_mid();
        test_mid_gap();
        test_soak();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
